// File: rtl/rf_pkg.sv
// Shared constants, collector state encoding and lane helpers for the
// register-bank operand collector slice.
package rf_pkg;

    localparam int LANES = 8;
    localparam int WIDTH = 32;
    localparam int NREG  = 16;
    localparam int AW    = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } coll_state_e;

    function automatic logic [WIDTH-1:0] lane_slice(input logic [LANES*WIDTH-1:0] vec,
                                                    input int lane);
        return vec[lane*WIDTH +: WIDTH];
    endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-lane operand select for one bank read port: zero for unused operands or
// inactive lanes, same-cycle writeback data where it hits, bank data otherwise.
module rf_bypass_mux
    import rf_pkg::*;
(
    input  logic [LANES*WIDTH-1:0] bank_data,
    input  logic [LANES*WIDTH-1:0] wb_data,
    input  logic [LANES-1:0]       wb_mask,
    input  logic                   addr_match,
    input  logic                   use_op,
    input  logic [LANES-1:0]       lane_mask,
    output logic [LANES*WIDTH-1:0] sel_data
);

    // The bank commits the writeback on the same edge we capture, so its read
    // data is stale; forward the writeback lane instead.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (use_op && lane_mask[i]) begin
                if (addr_match && wb_mask[i])
                    sel_data[i*WIDTH +: WIDTH] = lane_slice(wb_data, i);
                else
                    sel_data[i*WIDTH +: WIDTH] = lane_slice(bank_data, i);
            end
        end
    end

endmodule

// File: rtl/rf_operand_collector.sv
// Issue-side register-bank initiator: reads both source operands in one READ
// cycle, forwards writebacks to the bank and holds the bundle until consumed.
module rf_operand_collector
    import rf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_valid,
    output logic                   iss_ready,
    input  logic [AW-1:0]          iss_src0,
    input  logic [AW-1:0]          iss_src1,
    input  logic                   iss_use0,
    input  logic                   iss_use1,
    input  logic [LANES-1:0]       iss_mask,
    output logic [LANES-1:0]       rb_read_en_0,
    output logic [AW-1:0]          rb_raddr_0,
    output logic [LANES-1:0]       rb_read_en_1,
    output logic [AW-1:0]          rb_raddr_1,
    input  logic [LANES*WIDTH-1:0] rb_rdata_0,
    input  logic [LANES*WIDTH-1:0] rb_rdata_1,
    input  logic                   wb_valid,
    input  logic [AW-1:0]          wb_addr,
    input  logic [LANES-1:0]       wb_mask,
    input  logic [LANES*WIDTH-1:0] wb_data,
    output logic [LANES-1:0]       rb_write_en,
    output logic [AW-1:0]          rb_waddr,
    output logic [LANES*WIDTH-1:0] rb_wdata,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [LANES*WIDTH-1:0] op_a,
    output logic [LANES*WIDTH-1:0] op_b,
    output logic [LANES-1:0]       op_mask
);

    coll_state_e            state;
    logic [AW-1:0]          req_src0;
    logic [AW-1:0]          req_src1;
    logic                   req_use0;
    logic                   req_use1;
    logic [LANES-1:0]       req_mask;
    logic                   in_read;
    logic                   accept;
    logic                   match0;
    logic                   match1;
    logic [LANES*WIDTH-1:0] sel_a;
    logic [LANES*WIDTH-1:0] sel_b;

    assign in_read   = (state == READ);
    assign iss_ready = (state == IDLE) || ((state == HOLD) && op_ready);
    assign accept    = iss_valid && iss_ready;

    assign rb_raddr_0   = req_src0;
    assign rb_raddr_1   = req_src1;
    assign rb_read_en_0 = (in_read && req_use0) ? req_mask : '0;
    assign rb_read_en_1 = (in_read && req_use1) ? req_mask : '0;

    // Writeback is a pure passthrough, gated only so reset silences the bank.
    assign rb_write_en = (wb_valid && !rst) ? wb_mask : '0;
    assign rb_waddr    = wb_addr;
    assign rb_wdata    = wb_data;

    assign match0 = wb_valid && (wb_addr == req_src0);
    assign match1 = wb_valid && (wb_addr == req_src1);

    rf_bypass_mux u_mux_a (
        .bank_data  (rb_rdata_0),
        .wb_data    (wb_data),
        .wb_mask    (wb_mask),
        .addr_match (match0),
        .use_op     (req_use0),
        .lane_mask  (req_mask),
        .sel_data   (sel_a)
    );

    rf_bypass_mux u_mux_b (
        .bank_data  (rb_rdata_1),
        .wb_data    (wb_data),
        .wb_mask    (wb_mask),
        .addr_match (match1),
        .use_op     (req_use1),
        .lane_mask  (req_mask),
        .sel_data   (sel_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_src0 <= '0;
            req_src1 <= '0;
            req_use0 <= 1'b0;
            req_use1 <= 1'b0;
            req_mask <= '0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_mask  <= '0;
        end else begin
            if (accept) begin
                req_src0 <= iss_src0;
                req_src1 <= iss_src1;
                req_use0 <= iss_use0;
                req_use1 <= iss_use1;
                req_mask <= iss_mask;
            end
            case (state)
                IDLE: begin
                    if (iss_valid)
                        state <= READ;
                end
                READ: begin
                    op_a     <= sel_a;
                    op_b     <= sel_b;
                    op_mask  <= req_mask;
                    op_valid <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= iss_valid ? READ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_operand_collector.sv
// Randomised and directed bench for rf_operand_collector against a
// transaction-level model with an emulated register bank.
module tb_rf_operand_collector;
    import rf_pkg::*;

    localparam int DW = LANES*WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              iss_valid, iss_ready, iss_use0, iss_use1;
    logic [AW-1:0]     iss_src0, iss_src1;
    logic [LANES-1:0]  iss_mask;
    logic [LANES-1:0]  rb_read_en_0, rb_read_en_1, rb_write_en;
    logic [AW-1:0]     rb_raddr_0, rb_raddr_1, rb_waddr;
    logic [DW-1:0]     rb_rdata_0, rb_rdata_1, rb_wdata;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [LANES-1:0]  wb_mask;
    logic [DW-1:0]     wb_data;
    logic              op_valid, op_ready;
    logic [DW-1:0]     op_a, op_b;
    logic [LANES-1:0]  op_mask;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    rf_operand_collector dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src0(iss_src0), .iss_src1(iss_src1),
        .iss_use0(iss_use0), .iss_use1(iss_use1), .iss_mask(iss_mask),
        .rb_read_en_0(rb_read_en_0), .rb_raddr_0(rb_raddr_0),
        .rb_read_en_1(rb_read_en_1), .rb_raddr_1(rb_raddr_1),
        .rb_rdata_0(rb_rdata_0), .rb_rdata_1(rb_rdata_1),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_mask(wb_mask), .wb_data(wb_data),
        .rb_write_en(rb_write_en), .rb_waddr(rb_waddr), .rb_wdata(rb_wdata),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_mask(op_mask)
    );

    // Emulated register_bank, written only through the collector's write port.
    logic [WIDTH-1:0] bank [NREG][LANES];

    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (rb_write_en[i]) bank[rb_waddr][i] <= rb_wdata[i*WIDTH +: WIDTH];
    end

    always_comb begin
        rb_rdata_0 = '0;
        rb_rdata_1 = '0;
        for (int i = 0; i < LANES; i++) begin
            rb_rdata_0[i*WIDTH +: WIDTH] = bank[rb_raddr_0][i];
            rb_rdata_1[i*WIDTH +: WIDTH] = bank[rb_raddr_1][i];
        end
    end

    // Reference model: current request being read, current bundle, own bank copy.
    logic [WIDTH-1:0] ref_bank [NREG][LANES];
    logic             m_read, m_have, m_use0, m_use1;
    logic [AW-1:0]    m_src0, m_src1;
    logic [LANES-1:0] m_mask, m_omask;
    logic [DW-1:0]    m_a, m_b;
    logic             n_read, n_have, n_use0, n_use1;
    logic [AW-1:0]    n_src0, n_src1;
    logic [LANES-1:0] n_mask, n_omask;
    logic [DW-1:0]    n_a, n_b;
    logic             p_wv;
    logic [AW-1:0]    p_wa;
    logic [LANES-1:0] p_wm;
    logic [DW-1:0]    p_wd;
    logic             e_iss_ready, last_accept;
    logic [LANES-1:0] e_ren0, e_ren1, e_wen;

    function automatic logic [DW-1:0] ref_operand(input logic [AW-1:0] src, input logic use_op,
                                                  input logic [LANES-1:0] mask);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!use_op || !mask[i])
                v[i*WIDTH +: WIDTH] = '0;
            else if (wb_valid && wb_addr == src && wb_mask[i])
                v[i*WIDTH +: WIDTH] = wb_data[i*WIDTH +: WIDTH];
            else
                v[i*WIDTH +: WIDTH] = ref_bank[src][i];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_read = 0; m_have = 0; m_use0 = 0; m_use1 = 0;
        m_src0 = '0; m_src1 = '0; m_mask = '0; m_omask = '0; m_a = '0; m_b = '0;
        n_read = 0; n_have = 0; n_use0 = 0; n_use1 = 0;
        n_src0 = '0; n_src1 = '0; n_mask = '0; n_omask = '0; n_a = '0; n_b = '0;
        p_wv = 0; p_wa = '0; p_wm = '0; p_wd = '0;
        last_accept = 0;
    endtask

    task automatic model_commit();
        m_read = n_read; m_have = n_have; m_use0 = n_use0; m_use1 = n_use1;
        m_src0 = n_src0; m_src1 = n_src1; m_mask = n_mask; m_omask = n_omask;
        m_a = n_a; m_b = n_b;
        if (p_wv)
            for (int i = 0; i < LANES; i++)
                if (p_wm[i]) ref_bank[p_wa][i] = p_wd[i*WIDTH +: WIDTH];
        p_wv = 0;
    endtask

    // Expected outputs for this cycle, and what the next edge must produce.
    task automatic model_eval();
        e_iss_ready = !m_read && (!m_have || op_ready);
        e_ren0 = (m_read && m_use0) ? m_mask : '0;
        e_ren1 = (m_read && m_use1) ? m_mask : '0;
        e_wen  = wb_valid ? wb_mask : '0;
        n_read = m_read; n_have = m_have; n_use0 = m_use0; n_use1 = m_use1;
        n_src0 = m_src0; n_src1 = m_src1; n_mask = m_mask; n_omask = m_omask;
        n_a = m_a; n_b = m_b;
        if (m_read) begin
            n_a = ref_operand(m_src0, m_use0, m_mask);
            n_b = ref_operand(m_src1, m_use1, m_mask);
            n_omask = m_mask;
            n_have = 1;
            n_read = 0;
        end else if (m_have && op_ready) begin
            n_have = 0;
        end
        last_accept = iss_valid && e_iss_ready;
        if (last_accept) begin
            n_read = 1;
            n_src0 = iss_src0; n_src1 = iss_src1;
            n_use0 = iss_use0; n_use1 = iss_use1; n_mask = iss_mask;
        end
        p_wv = wb_valid; p_wa = wb_addr; p_wm = wb_mask; p_wd = wb_data;
    endtask

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("iss_ready", DW'(iss_ready), DW'(e_iss_ready));
            check_output("rb_read_en_0", DW'(rb_read_en_0), DW'(e_ren0));
            check_output("rb_read_en_1", DW'(rb_read_en_1), DW'(e_ren1));
            check_output("rb_raddr_0", DW'(rb_raddr_0), DW'(m_src0));
            check_output("rb_raddr_1", DW'(rb_raddr_1), DW'(m_src1));
            check_output("rb_write_en", DW'(rb_write_en), DW'(e_wen));
            check_output("rb_waddr", DW'(rb_waddr), DW'(wb_addr));
            check_output("rb_wdata", rb_wdata, wb_data);
            check_output("op_valid", DW'(op_valid), DW'(m_have));
            if (m_have) begin
                check_output("op_a", op_a, m_a);
                check_output("op_b", op_b, m_b);
                check_output("op_mask", DW'(op_mask), DW'(m_omask));
            end
        end
    end

    task automatic apply_stimulus(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                                  input logic u0, input logic u1, input logic [LANES-1:0] m,
                                  input logic rdy, input logic wv, input logic [AW-1:0] wa,
                                  input logic [LANES-1:0] wm, input logic [DW-1:0] wd);
        @(posedge clk);
        #1;
        model_commit();
        iss_valid = v; iss_src0 = s0; iss_src1 = s1; iss_use0 = u0; iss_use1 = u1;
        iss_mask = m; op_ready = rdy;
        wb_valid = wv; wb_addr = wa; wb_mask = wm; wb_data = wd;
        model_eval();
    endtask

    task automatic issue(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic u0,
                         input logic u1, input logic [LANES-1:0] m, input logic rdy);
        apply_stimulus(1'b1, s0, s1, u0, u1, m, rdy, 1'b0, '0, '0, '0);
    endtask

    task automatic idle(input logic rdy);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, rdy, 1'b0, '0, '0, '0);
    endtask

    logic [DW-1:0] lit_r3, lit_r5, lit_exp, wd;
    logic [AW-1:0] r_s0, r_s1, r_wa;
    logic [LANES-1:0] r_m;
    logic r_v, r_u0, r_u1, hold_req;

    initial begin
        rst = 1'b1;
        iss_valid = 0; iss_src0 = '0; iss_src1 = '0; iss_use0 = 0; iss_use1 = 0;
        iss_mask = '0; op_ready = 0;
        wb_valid = 1'b1; wb_addr = 4'd2; wb_mask = 8'hFF; wb_data = '0;
        model_reset();
        for (int i = 0; i < LANES; i++) begin
            lit_r3[i*WIDTH +: WIDTH] = 32'h0300_0000 + i;
            lit_r5[i*WIDTH +: WIDTH] = 32'h0500_0000 + i;
        end

        repeat (3) @(posedge clk);
        #2;
        check_output("reset op_valid", DW'(op_valid), '0);
        check_output("reset op_a", op_a, '0);
        check_output("reset op_b", op_b, '0);
        check_output("reset op_mask", DW'(op_mask), '0);
        check_output("reset rb_write_en", DW'(rb_write_en), '0);
        check_output("reset rb_read_en_0", DW'(rb_read_en_0), '0);
        check_output("reset iss_ready", DW'(iss_ready), DW'(1'b1));
        wb_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Preload every register through the writeback passthrough.
        for (int r = 0; r < NREG; r++) begin
            if (r == 3) wd = lit_r3;
            else if (r == 5) wd = lit_r5;
            else for (int i = 0; i < LANES; i++) wd[i*WIDTH +: WIDTH] = $urandom;
            apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(r), 8'hFF, wd);
            chk_en = 1'b1;
        end
        idle(1'b1);

        // Full-mask read of r3/r5 with latency checks.
        issue(4'd3, 4'd5, 1'b1, 1'b1, 8'hFF, 1'b1);
        idle(1'b1); #1;
        check_output("t1 read_en_0 N+1", DW'(rb_read_en_0), DW'(8'hFF));
        check_output("t1 read_en_1 N+1", DW'(rb_read_en_1), DW'(8'hFF));
        check_output("t1 raddr_0", DW'(rb_raddr_0), DW'(4'd3));
        check_output("t1 op_valid N+1", DW'(op_valid), '0);
        idle(1'b1); #1;
        check_output("t1 op_valid N+2", DW'(op_valid), DW'(1'b1));
        check_output("t1 read_en_0 N+2", DW'(rb_read_en_0), '0);
        check_output("t1 op_a", op_a, lit_r3);
        check_output("t1 op_b", op_b, lit_r5);

        // Partial lane mask.
        issue(4'd3, 4'd5, 1'b1, 1'b1, 8'h0F, 1'b1);
        idle(1'b1); #1;
        check_output("t2 read_en_0", DW'(rb_read_en_0), DW'(8'h0F));
        idle(1'b1); #1;
        lit_exp = lit_r3;
        lit_exp[DW-1:4*WIDTH] = '0;
        check_output("t2 op_a", op_a, lit_exp);
        lit_exp = lit_r5;
        lit_exp[DW-1:4*WIDTH] = '0;
        check_output("t2 op_b", op_b, lit_exp);

        // Same-cycle writeback bypass into operand A.
        issue(4'd3, 4'd5, 1'b1, 1'b1, 8'hFF, 1'b1);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd3, 8'h01,
                       {224'h0, 32'hDEADBEEF});
        idle(1'b1); #1;
        lit_exp = lit_r3;
        lit_exp[WIDTH-1:0] = 32'hDEADBEEF;
        check_output("t3 op_a bypass", op_a, lit_exp);
        check_output("t3 op_b", op_b, lit_r5);
        check_output("t3 bank r3 lane0", DW'(bank[3][0]), DW'(32'hDEADBEEF));

        // Operand B unused.
        issue(4'd5, 4'd3, 1'b1, 1'b0, 8'hFF, 1'b1);
        idle(1'b1); #1;
        check_output("t4 read_en_1", DW'(rb_read_en_1), '0);
        idle(1'b1); #1;
        check_output("t4 op_a", op_a, lit_r5);
        check_output("t4 op_b", op_b, '0);

        // Backpressure: bundle must stay stable while a writeback hits r5.
        issue(4'd5, 4'd3, 1'b1, 1'b1, 8'hFF, 1'b0);
        idle(1'b0);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 4'd5, 8'hFF,
                           {8{32'h5A5A_0000 + 32'(k)}});
            #1;
            check_output("t5 iss_ready held", DW'(iss_ready), '0);
            check_output("t5 op_a stable", op_a, lit_r5);
        end
        issue(4'd3, 4'd5, 1'b1, 1'b1, 8'hFF, 1'b1); #1;
        check_output("t5 iss_ready release", DW'(iss_ready), DW'(1'b1));
        idle(1'b1); #1;
        check_output("t5 op_valid gap", DW'(op_valid), '0);
        idle(1'b1); #1;
        lit_exp = lit_r3;
        lit_exp[WIDTH-1:0] = 32'hDEADBEEF;
        check_output("t5 next op_valid", DW'(op_valid), DW'(1'b1));
        check_output("t5 next op_a", op_a, lit_exp);

        // Asynchronous reset during READ.
        issue(4'd3, 4'd5, 1'b1, 1'b1, 8'hFF, 1'b1);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd7, 8'hFF, '0);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_output("t6 rst read_en_0", DW'(rb_read_en_0), '0);
        check_output("t6 rst read_en_1", DW'(rb_read_en_1), '0);
        check_output("t6 rst write_en", DW'(rb_write_en), '0);
        check_output("t6 rst op_valid", DW'(op_valid), '0);
        wb_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_output("t6 iss_ready after rst", DW'(iss_ready), DW'(1'b1));
        check_output("t6 op_valid after rst", DW'(op_valid), '0);
        idle(1'b1);
        chk_en = 1'b1;

        // Randomised traffic with bypass-biased writebacks.
        hold_req = 1'b0;
        r_v = 0; r_s0 = '0; r_s1 = '0; r_u0 = 0; r_u1 = 0; r_m = '0;
        for (int c = 0; c < 800; c++) begin
            if (!hold_req) begin
                r_v  = ($urandom_range(0, 9) < 6);
                r_s0 = AW'($urandom);
                r_s1 = $urandom_range(0, 3) == 0 ? r_s0 : AW'($urandom);
                r_u0 = ($urandom_range(0, 4) != 0);
                r_u1 = ($urandom_range(0, 4) != 0);
                r_m  = LANES'($urandom);
            end
            r_wa = $urandom_range(0, 1) ? m_src0 : ($urandom_range(0, 1) ? m_src1 : AW'($urandom));
            for (int i = 0; i < LANES; i++) wd[i*WIDTH +: WIDTH] = $urandom;
            apply_stimulus(r_v, r_s0, r_s1, r_u0, r_u1, r_m, ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 1) == 1), r_wa, LANES'($urandom), wd);
            hold_req = r_v && !last_accept;
        end
        idle(1'b1);
        idle(1'b1);
        @(posedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
